// File: rtl/ntlm_proto_pkg.sv
// ntlm_proto_pkg: framing byte codes and framer state encoding.
// Shared by the hash framer and its environment.
package ntlm_proto_pkg;

  localparam logic [7:0] BYTE_START = 8'hAA;
  localparam logic [7:0] BYTE_CONT  = 8'h88;
  localparam logic [7:0] BYTE_STOP  = 8'hEE;
  localparam logic [7:0] BYTE_PROG  = 8'h6C;

  typedef enum logic [2:0] {
    IDLE,
    SEND_START,
    SEND_HASH,
    SEND_SEP,
    ACCEPT,
    ARMED,
    SEND_PROG,
    COLLECT
  } framer_state_t;

endpackage

// File: rtl/hash_framer_if.sv
// hash_framer_if: hash stream, UART tx/rx and result signals.
// slave is the framer side, master the environment side.
interface hash_framer_if;

  logic         hash_valid;
  logic [127:0] hash_data;
  logic         hash_last;
  logic         hash_ready;
  logic [7:0]   tx_byte;
  logic         tx_start;
  logic         tx_done;
  logic         prog_req;
  logic [7:0]   rx_byte;
  logic         rx_valid;
  logic [7:0]   res_byte;
  logic         res_valid;
  logic         res_done;
  logic         busy;
  logic         err;

  modport slave (
    input  hash_valid, hash_data, hash_last,
    input  tx_done, prog_req, rx_byte, rx_valid,
    output hash_ready, tx_byte, tx_start,
    output res_byte, res_valid, res_done, busy, err
  );

  modport master (
    output hash_valid, hash_data, hash_last,
    output tx_done, prog_req, rx_byte, rx_valid,
    input  hash_ready, tx_byte, tx_start,
    input  res_byte, res_valid, res_done, busy, err
  );

endinterface

// File: rtl/hash_framer.sv
// hash_framer: frames target hashes onto a UART and collects results.
// Optional watchdog built when HASH_FRAMER_TIMEOUT_EN is defined.
import ntlm_proto_pkg::*;

module hash_framer #(
  parameter int unsigned RESULT_BYTES   = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic          clk,
  input  logic          rst,
  hash_framer_if.slave  bus
);

  localparam int RES_W = $clog2(RESULT_BYTES + 1);
  localparam logic [RES_W-1:0] RES_LAST =
    RES_W'(RESULT_BYTES - 1);

  framer_state_t    state;
  framer_state_t    state_nx;
  logic [127:0]     hash_q;
  logic             last_q;
  logic [3:0]       k_q;
  logic [RES_W-1:0] res_cnt;
  logic             sent_q;

  logic             ready_q;
  logic             busy_q;
  logic             tx_start_q;
  logic [7:0]       tx_byte_q;
  logic             res_valid_q;
  logic             res_done_q;
  logic [7:0]       res_byte_q;
  logic             err_q;

  logic             is_send;
  logic             hs;
  logic             issue;
  logic             tx_ack;
  logic             rx_take;
  logic             res_hit;
  logic             wd_exp;
  logic [7:0]       byte_nx;
  logic             ready_nx;
  logic             busy_nx;

  assign is_send = state inside
    {SEND_START, SEND_HASH, SEND_SEP, SEND_PROG};
  assign hs      = bus.hash_valid && ready_q;
  assign issue   = is_send && !sent_q;
  // a tx_done landing on the tx_start cycle is not ours
  assign tx_ack  = is_send && sent_q && !tx_start_q
                && bus.tx_done;
  assign rx_take = (state == COLLECT) && bus.rx_valid;
  assign res_hit = rx_take && (res_cnt == RES_LAST);

`ifdef HASH_FRAMER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            wd_run;

  assign wd_run = (is_send && sent_q)
               || (state == COLLECT);
  assign wd_exp = wd_run && !tx_ack && !rx_take
               && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  // watchdog: counts idle wait cycles, reloads on progress
  always_ff @(posedge clk) begin
    if (rst || !wd_run || tx_ack || rx_take || wd_exp)
      wd_cnt <= '0;
    else
      wd_cnt <= wd_cnt + 1'b1;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign wd_exp = 1'b0;
`endif

  // state register and frame datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      hash_q  <= '0;
      last_q  <= 1'b0;
      k_q     <= '0;
      res_cnt <= '0;
      sent_q  <= 1'b0;
    end else begin
      state <= state_nx;
      if (hs) begin
        hash_q <= bus.hash_data;
        last_q <= bus.hash_last;
      end
      if (state_nx != state || tx_ack)
        sent_q <= 1'b0;
      else if (issue)
        sent_q <= 1'b1;
      if (state_nx != SEND_HASH)
        k_q <= '0;
      else if (state == SEND_HASH && tx_ack)
        k_q <= k_q + 4'd1;
      if (state == SEND_PROG && tx_ack)
        res_cnt <= '0;
      else if (rx_take)
        res_cnt <= res_cnt + 1'b1;
    end
  end

  // next-state decode
  always_comb begin
    state_nx = state;
    if (wd_exp) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:
          if (hs) state_nx = SEND_START;
        SEND_START:
          if (tx_ack) state_nx = SEND_HASH;
        SEND_HASH:
          if (tx_ack && k_q == 4'hF)
            state_nx = SEND_SEP;
        SEND_SEP:
          if (tx_ack)
            state_nx = last_q ? ARMED : ACCEPT;
        ACCEPT:
          if (hs) state_nx = SEND_HASH;
        ARMED:
          if (bus.prog_req) state_nx = SEND_PROG;
        SEND_PROG:
          if (tx_ack) state_nx = COLLECT;
        COLLECT:
          if (res_hit) state_nx = ARMED;
        default:
          state_nx = IDLE;
      endcase
    end
  end

  // output decode: next tx byte and status levels
  always_comb begin
    byte_nx  = 8'h00;
    ready_nx = state_nx inside {IDLE, ACCEPT};
    busy_nx  = !(state_nx inside {IDLE, ARMED});
    unique case (1'b1)
      state == SEND_START: byte_nx = BYTE_START;
      state == SEND_HASH:
        byte_nx = hash_q[{~k_q, 3'b000} +: 8];
      state == SEND_SEP:
        byte_nx = last_q ? BYTE_STOP : BYTE_CONT;
      state == SEND_PROG:  byte_nx = BYTE_PROG;
      default:             byte_nx = 8'h00;
    endcase
  end

  // registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      tx_start_q  <= 1'b0;
      tx_byte_q   <= '0;
      res_valid_q <= 1'b0;
      res_done_q  <= 1'b0;
      res_byte_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      ready_q     <= ready_nx;
      busy_q      <= busy_nx;
      tx_start_q  <= issue;
      if (issue) tx_byte_q <= byte_nx;
      res_valid_q <= rx_take;
      res_done_q  <= res_hit;
      if (rx_take) res_byte_q <= bus.rx_byte;
      err_q       <= wd_exp;
    end
  end

  assign bus.hash_ready = ready_q;
  assign bus.busy       = busy_q;
  assign bus.tx_start   = tx_start_q;
  assign bus.tx_byte    = tx_byte_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_done   = res_done_q;
  assign bus.res_byte   = res_byte_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_hash_framer.sv
// tb_hash_framer: scoreboard bench for hash_framer.
// Expected tx/result bytes are queued as stimulus is driven.
module tb_hash_framer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hash_framer_if bus();

  hash_framer #(
    .RESULT_BYTES(1024),
    .TIMEOUT_CYCLES(100000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  int tx_total = 0;
  int res_total = 0;
  int resp_n = 0;
  int resp_done_n = 0;
  int done_limit = 32'h3fff_ffff;
  logic [7:0] tx_q[$];
  logic [8:0] res_q[$];

  task automatic check(input string tag,
                       input logic [127:0] act,
                       input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, act, exp);
    end
  endtask

  // output monitor
  always @(negedge clk) begin
    if (bus.tx_start === 1'b1) begin
      tx_total++;
      if (tx_q.size() == 0)
        check("tx_unexpected", bus.tx_start, 1'b0);
      else
        check("tx_byte", bus.tx_byte, tx_q.pop_front());
    end
    if (bus.res_valid === 1'b1) begin
      res_total++;
      if (res_q.size() == 0)
        check("res_unexpected", bus.res_valid, 1'b0);
      else
        check("res_byte", {bus.res_done, bus.res_byte},
              res_q.pop_front());
    end else if (bus.res_done !== 1'b0) begin
      check("res_done_alone", bus.res_done, 1'b0);
    end
  end

  // UART transmitter model
  initial begin
    int d;
    bus.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_start === 1'b1) begin
        resp_n++;
        if (resp_n <= done_limit) begin
          bus.tx_done = resp_n[0];
          d = 1 + $urandom_range(0, 3);
          repeat (d) begin
            @(negedge clk);
            bus.tx_done = 1'b0;
            check("tx_start_hold", bus.tx_start, 1'b0);
          end
          bus.tx_done = 1'b1;
          @(negedge clk);
          bus.tx_done = 1'b0;
          resp_done_n++;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected done");
    $fatal(1, "bench timeout");
  end

  task automatic send_hash(input logic [127:0] h,
                           input logic last,
                           input logic first);
    logic ok;
    ok = 1'b0;
    if (first) tx_q.push_back(8'hAA);
    for (int k = 0; k < 16; k++)
      tx_q.push_back(h[127-8*k -: 8]);
    tx_q.push_back(last ? 8'hEE : 8'h88);
    bus.hash_valid = 1'b1;
    bus.hash_data  = h;
    bus.hash_last  = last;
    for (int i = 0; i < 2000 && !ok; i++) begin
      if (bus.hash_ready) begin
        @(posedge clk);
        ok = 1'b1;
      end
      @(negedge clk);
    end
    bus.hash_valid = 1'b0;
    check("hash_accept", ok, 1'b1);
    check("ready_drop", bus.hash_ready, 1'b0);
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      if (tx_q.size() == 0 && !bus.busy) done = 1'b1;
      else @(negedge clk);
    end
    check("drain_done", done, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tx_q.delete();
    res_q.delete();
  endtask

  initial begin
    int base;
    int rbase;
    int target;
    logic ok;
    rst = 1'b1;
    bus.hash_valid = 1'b0;
    bus.hash_data  = '0;
    bus.hash_last  = 1'b0;
    bus.prog_req   = 1'b0;
    bus.rx_byte    = '0;
    bus.rx_valid   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_ready", bus.hash_ready, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_tx_start", bus.tx_start, 1'b0);
    check("rst_tx_byte", bus.tx_byte, 8'h00);
    check("rst_res_valid", bus.res_valid, 1'b0);
    check("rst_res_byte", bus.res_byte, 8'h00);
    check("rst_err", bus.err, 1'b0);

    bus.prog_req = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_byte  = 8'h5A;
    @(negedge clk);
    bus.prog_req = 1'b0;
    bus.rx_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_busy", bus.busy, 1'b0);
    check("idle_ready", bus.hash_ready, 1'b1);
    check("idle_tx", tx_total, 0);

    base = tx_total;
    send_hash(128'h00112233445566778899AABBCCDDEEFF,
              1'b1, 1'b1);
    drain();
    check("single_len", tx_total - base, 18);
    check("armed_busy", bus.busy, 1'b0);
    check("armed_ready", bus.hash_ready, 1'b0);

    base = tx_total;
    bus.hash_valid = 1'b1;
    bus.hash_data  = {4{$urandom}};
    bus.hash_last  = 1'b1;
    repeat (10) @(negedge clk);
    check("armed_ignore_ready", bus.hash_ready, 1'b0);
    check("armed_ignore_tx", tx_total - base, 0);
    bus.hash_valid = 1'b0;

    bus.rx_valid = 1'b1;
    repeat (3) @(negedge clk);
    bus.rx_valid = 1'b0;

    target = resp_done_n + 1;
    tx_q.push_back(8'h6C);
    bus.prog_req = 1'b1;
    @(negedge clk);
    bus.prog_req = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (resp_done_n >= target) ok = 1'b1;
      else @(negedge clk);
    end
    check("prog_sent", ok, 1'b1);
    @(negedge clk);
    check("collect_busy", bus.busy, 1'b1);

    rbase = res_total;
    for (int i = 0; i < 1024; i++) begin
      res_q.push_back({(i == 1023), i[7:0]});
      bus.rx_byte  = i[7:0];
      bus.rx_valid = 1'b1;
      @(negedge clk);
      bus.rx_valid = 1'b0;
      if (i % 7 == 3) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check("res_count", res_total - rbase, 1024);
    check("res_q_empty", res_q.size(), 0);
    check("post_res_busy", bus.busy, 1'b0);
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("drop_rx", res_total - rbase, 1024);

    do_reset();
    base = tx_total;
    send_hash({4{32'hDEADBEEF}} ^ 128'h0123, 1'b0, 1'b1);
    bus.prog_req = 1'b1;
    @(negedge clk);
    bus.prog_req = 1'b0;
    send_hash(128'hFEDCBA98765432100F1E2D3C4B5A6978,
              1'b1, 1'b0);
    drain();
    check("two_len", tx_total - base, 35);
    check("two_busy", bus.busy, 1'b0);

    do_reset();
    base = tx_total;
    done_limit = resp_n + 6;
    send_hash(128'hA5A5_0000_1111_2222_3333_4444_5555_6666,
              1'b1, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      if (tx_total - base >= 7) ok = 1'b1;
      else @(negedge clk);
    end
    check("mid_reach", ok, 1'b1);
    repeat (60) @(negedge clk);
    check("wait_busy", bus.busy, 1'b1);
    check("wait_err", bus.err, 1'b0);
    check("wait_len", tx_total - base, 7);
    rst = 1'b1;
    tx_q.delete();
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_ready", bus.hash_ready, 1'b1);
    check("mid_rst_busy", bus.busy, 1'b0);
    done_limit = 32'h3fff_ffff;
    repeat (30) @(negedge clk);
    check("after_rst_len", tx_total - base, 7);
    base = tx_total;
    send_hash(128'h13579BDF02468ACE1122334455667788,
              1'b1, 1'b1);
    drain();
    check("restart_len", tx_total - base, 18);

    check("tx_q_left", tx_q.size(), 0);
    check("res_q_left", res_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
